sgpr_sync_ctrl: RTL and testbench

//  Sequencer/arbiter for the shadow GPR file (sgpr). Mirrors core writeback into sgpr, runs a

---
 rtl/sgpr_pkg.sv | 21 ++
 rtl/sgpr_sync_ctrl_if.sv | 49 ++++
 rtl/sgpr_addr_seq.sv | 38 +++
 rtl/sgpr_sync_ctrl.sv | 113 +++++++++++
 tb/tb_sgpr_sync_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgpr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgpr_pkg : shared widths, walk bounds and FSM state type for sgpr ctrl   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package sgpr_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int FIRST_REG  = 1;
  localparam int LAST_REG   = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CKPT = 2'd1,
    RSTR = 2'd2,
    DONE = 2'd3
  } sgpr_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sgpr_sync_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgpr_sync_ctrl_if : core writeback, walk control, primary RF and sgpr    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface sgpr_sync_ctrl_if #(
  parameter int ADDR_WIDTH = sgpr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sgpr_pkg::DATA_WIDTH
);

  logic                  core_we_i;
  logic [ADDR_WIDTH-1:0] core_waddr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic                  ckpt_req_i;
  logic                  rstr_req_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  core_stall_o;
  logic [ADDR_WIDTH-1:0] prf_raddr_o;
  logic [DATA_WIDTH-1:0] prf_rdata_i;
  logic                  prf_we_o;
  logic [ADDR_WIDTH-1:0] prf_waddr_o;
  logic [DATA_WIDTH-1:0] prf_wdata_o;
  logic [ADDR_WIDTH-1:0] sgpr_raddr_a_o;
  logic [DATA_WIDTH-1:0] sgpr_rdata_a_i;
  logic                  sgpr_we_a_o;
  logic [ADDR_WIDTH-1:0] sgpr_waddr_a_o;
  logic [DATA_WIDTH-1:0] sgpr_wdata_a_o;

  // Controller side
  modport slave (
    input  core_we_i, core_waddr_i, core_wdata_i, ckpt_req_i, rstr_req_i,
    input  prf_rdata_i, sgpr_rdata_a_i,
    output busy_o, done_o, core_stall_o,
    output prf_raddr_o, prf_we_o, prf_waddr_o, prf_wdata_o,
    output sgpr_raddr_a_o, sgpr_we_a_o, sgpr_waddr_a_o, sgpr_wdata_a_o
  );

  // Environment side: core, primary RF and sgpr storage
  modport master (
    output core_we_i, core_waddr_i, core_wdata_i, ckpt_req_i, rstr_req_i,
    output prf_rdata_i, sgpr_rdata_a_i,
    input  busy_o, done_o, core_stall_o,
    input  prf_raddr_o, prf_we_o, prf_waddr_o, prf_wdata_o,
    input  sgpr_raddr_a_o, sgpr_we_a_o, sgpr_waddr_a_o, sgpr_wdata_a_o
  );

endinterface
`default_nettype wire

// File: rtl/sgpr_addr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgpr_addr_seq : walk address counter FIRST_REG..LAST_REG with last flag  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sgpr_addr_seq
  import sgpr_pkg::*;
#(
  parameter int ADDR_WIDTH = sgpr_pkg::ADDR_WIDTH,
  parameter int FIRST_REG  = sgpr_pkg::FIRST_REG,
  parameter int LAST_REG   = sgpr_pkg::LAST_REG
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  load,
  input  wire logic                  en,
  output      logic [ADDR_WIDTH-1:0] cnt,
  output      logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);

  assign last = (cnt == LAST_ADDR);

  // Wraps back to the first address on the final productive step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FIRST_ADDR;
    end else if (load || (en && last)) begin
      cnt <= FIRST_ADDR;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sgpr_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgpr_sync_ctrl : writeback mirror plus checkpoint/restore walk sequencer |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sgpr_sync_ctrl
  import sgpr_pkg::*;
#(
  parameter int ADDR_WIDTH = sgpr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sgpr_pkg::DATA_WIDTH,
  parameter int FIRST_REG  = sgpr_pkg::FIRST_REG,
  parameter int LAST_REG   = sgpr_pkg::LAST_REG
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sgpr_sync_ctrl_if.slave   bus
);

  sgpr_ctrl_state_t      state;
  sgpr_ctrl_state_t      state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  cnt_last;
  logic                  seq_en;
  logic                  mirror_hit;

  sgpr_addr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIRST_REG  (FIRST_REG),
    .LAST_REG   (LAST_REG)
  ) u_addr_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE),
    .en    (seq_en),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Core writes to x0 never reach sgpr; during restore the core is stalled
  assign mirror_hit = rst_n && bus.core_we_i && (bus.core_waddr_i != '0) && (state != RSTR);

  assign bus.busy_o       = (state != IDLE);
  assign bus.done_o       = (state == DONE);
  assign bus.core_stall_o = (state == RSTR);

  always_comb begin
    state_nxt          = state;
    seq_en             = 1'b0;
    bus.prf_raddr_o    = '0;
    bus.prf_we_o       = 1'b0;
    bus.prf_waddr_o    = '0;
    bus.prf_wdata_o    = '0;
    bus.sgpr_raddr_a_o = '0;
    bus.sgpr_we_a_o    = 1'b0;
    bus.sgpr_waddr_a_o = '0;
    bus.sgpr_wdata_a_o = '0;

    if (mirror_hit) begin
      bus.sgpr_we_a_o    = 1'b1;
      bus.sgpr_waddr_a_o = bus.core_waddr_i;
      bus.sgpr_wdata_a_o = bus.core_wdata_i;
    end

    case (state)
      IDLE: begin
        if (bus.rstr_req_i) begin
          state_nxt = RSTR;
        end else if (bus.ckpt_req_i) begin
          state_nxt = CKPT;
        end
      end
      CKPT: begin
        bus.prf_raddr_o = cnt;
        // Mirror owns the sgpr write port this cycle; the walk retries the same address
        if (!mirror_hit) begin
          bus.sgpr_we_a_o    = 1'b1;
          bus.sgpr_waddr_a_o = cnt;
          bus.sgpr_wdata_a_o = bus.prf_rdata_i;
          seq_en             = 1'b1;
          if (cnt_last) begin
            state_nxt = DONE;
          end
        end
      end
      RSTR: begin
        bus.sgpr_raddr_a_o = cnt;
        bus.prf_we_o       = 1'b1;
        bus.prf_waddr_o    = cnt;
        bus.prf_wdata_o    = bus.sgpr_rdata_a_i;
        seq_en             = 1'b1;
        if (cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sgpr_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sgpr_sync_ctrl : directed bench with primary RF and sgpr array models |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sgpr_sync_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sgpr_sync_ctrl_if ifc ();

  sgpr_sync_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic [31:0] prf_mem  [32];
  logic [31:0] sgpr_mem [32];

  assign ifc.prf_rdata_i    = prf_mem[ifc.prf_raddr_o];
  assign ifc.sgpr_rdata_a_i = sgpr_mem[ifc.sgpr_raddr_a_o];

  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int stall_first = 0;
  int stall_last  = 0;
  int prf_wr_cnt  = 0;
  logic prev_stall = 1'b0;
  int load_kind   = 0;
  int load_seq    = 0;
  int load_ack    = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Storage models, event recorders and the preload engine all live in one process
  always @(posedge clk) begin
    if (load_seq != load_ack) begin
      for (int i = 0; i < 32; i++) begin
        case (load_kind)
          1: begin prf_mem[i] = i * 3;     sgpr_mem[i] = 32'd0; end
          3: begin prf_mem[i] = 32'd0;     sgpr_mem[i] = i + 1000; end
          default: begin prf_mem[i] = i * 3 + 7; sgpr_mem[i] = 32'd0; end
        endcase
      end
      prf_mem[0]  = 32'hDEAD;
      sgpr_mem[0] = 32'h5A5A;
      load_ack    = load_seq;
    end
    if (ifc.done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ifc.core_stall_o) begin
      if (!prev_stall) stall_first = cyc;
      stall_last = cyc;
    end
    prev_stall = ifc.core_stall_o;
    if (ifc.prf_we_o) begin
      prf_mem[ifc.prf_waddr_o] = ifc.prf_wdata_o;
      prf_wr_cnt++;
    end
    if (ifc.sgpr_we_a_o) sgpr_mem[ifc.sgpr_waddr_a_o] = ifc.sgpr_wdata_a_o;
    if (rst_n && ifc.core_we_i && !ifc.core_stall_o && ifc.core_waddr_i != 5'd0)
      prf_mem[ifc.core_waddr_i] = ifc.core_wdata_i;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max);
    int k;
    k = 0;
    while (ifc.busy_o && k < max) begin
      tick();
      k++;
    end
    check("walk_timeout", {31'd0, ifc.busy_o}, 32'd0);
  endtask

  task automatic preload(input int kind);
    load_kind = kind;
    load_seq++;
    tick();
  endtask

  int n0;
  int d0;
  int p0;
  int errs;

  initial begin
    rst_n            = 1'b0;
    ifc.core_we_i    = 1'b1;
    ifc.core_waddr_i = 5'd10;
    ifc.core_wdata_i = 32'd100;
    ifc.ckpt_req_i   = 1'b0;
    ifc.rstr_req_i   = 1'b0;
    repeat (3) tick();

    // Reset state: everything quiet even with a core write presented
    check("rst_busy",   {31'd0, ifc.busy_o}, 32'd0);
    check("rst_done",   {31'd0, ifc.done_o}, 32'd0);
    check("rst_stall",  {31'd0, ifc.core_stall_o}, 32'd0);
    check("rst_prf_we", {31'd0, ifc.prf_we_o}, 32'd0);
    check("rst_sgpr_we", {31'd0, ifc.sgpr_we_a_o}, 32'd0);
    check("rst_prf_raddr", {27'd0, ifc.prf_raddr_o}, 32'd0);
    check("rst_sgpr_raddr", {27'd0, ifc.sgpr_raddr_a_o}, 32'd0);
    ifc.core_we_i = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: mirror in IDLE, x0 suppressed
    ifc.core_we_i    = 1'b1;
    ifc.core_waddr_i = 5'd0;
    ifc.core_wdata_i = 32'd55;
    #1;
    check("mirror_x0_we", {31'd0, ifc.sgpr_we_a_o}, 32'd0);
    ifc.core_waddr_i = 5'd10;
    ifc.core_wdata_i = 32'd100;
    #1;
    check("mirror_we",    {31'd0, ifc.sgpr_we_a_o}, 32'd1);
    check("mirror_waddr", {27'd0, ifc.sgpr_waddr_a_o}, 32'd10);
    check("mirror_wdata", ifc.sgpr_wdata_a_o, 32'd100);
    tick();
    ifc.core_we_i = 1'b0;
    check("mirror_stored", sgpr_mem[10], 32'd100);

    // 2: plain checkpoint
    preload(1);
    d0 = done_cnt;
    ifc.ckpt_req_i = 1'b1;
    n0 = cyc;
    tick();
    ifc.ckpt_req_i = 1'b0;
    check("ckpt_busy",  {31'd0, ifc.busy_o}, 32'd1);
    check("ckpt_waddr", {27'd0, ifc.sgpr_waddr_a_o}, 32'd1);
    check("ckpt_wdata", ifc.sgpr_wdata_a_o, 32'd3);
    run_until_idle(60);
    check("ckpt_done_cnt", done_cnt - d0, 32'd1);
    check("ckpt_done_lat", done_cyc - n0, 32'd32);
    errs = 0;
    for (int i = 1; i < 32; i++) if (sgpr_mem[i] !== 32'(i * 3)) errs++;
    check("ckpt_data_errs", errs, 32'd0);
    check("ckpt_x0_untouched", sgpr_mem[0], 32'h5A5A);

    // 3: collision with core write of x5 at N+3
    preload(1);
    d0 = done_cnt;
    ifc.ckpt_req_i = 1'b1;
    n0 = cyc;
    tick();
    ifc.ckpt_req_i = 1'b0;
    tick();
    tick();
    ifc.core_we_i    = 1'b1;
    ifc.core_waddr_i = 5'd5;
    ifc.core_wdata_i = 32'd69;
    #1;
    check("coll_waddr", {27'd0, ifc.sgpr_waddr_a_o}, 32'd5);
    check("coll_wdata", ifc.sgpr_wdata_a_o, 32'd69);
    tick();
    ifc.core_we_i = 1'b0;
    #1;
    check("coll_retry_addr", {27'd0, ifc.sgpr_waddr_a_o}, 32'd3);
    run_until_idle(60);
    check("coll_done_cnt", done_cnt - d0, 32'd1);
    check("coll_done_lat", done_cyc - n0, 32'd33);
    check("coll_x5", sgpr_mem[5], 32'd69);
    errs = 0;
    for (int i = 1; i < 32; i++) if (i != 5 && sgpr_mem[i] !== 32'(i * 3)) errs++;
    check("coll_data_errs", errs, 32'd0);

    // 4: restore walk, core write during stall ignored
    preload(3);
    d0 = done_cnt;
    p0 = prf_wr_cnt;
    ifc.rstr_req_i = 1'b1;
    n0 = cyc;
    tick();
    ifc.rstr_req_i = 1'b0;
    check("rstr_stall",     {31'd0, ifc.core_stall_o}, 32'd1);
    check("rstr_prf_we",    {31'd0, ifc.prf_we_o}, 32'd1);
    check("rstr_prf_waddr", {27'd0, ifc.prf_waddr_o}, 32'd1);
    check("rstr_prf_wdata", ifc.prf_wdata_o, 32'd1001);
    check("rstr_prf_raddr", {27'd0, ifc.prf_raddr_o}, 32'd0);
    repeat (4) tick();
    ifc.core_we_i    = 1'b1;
    ifc.core_waddr_i = 5'd7;
    ifc.core_wdata_i = 32'd7777;
    #1;
    check("rstr_core_ignored", {31'd0, ifc.sgpr_we_a_o}, 32'd0);
    tick();
    ifc.core_we_i = 1'b0;
    run_until_idle(60);
    check("rstr_prf_wr_cnt", prf_wr_cnt - p0, 32'd31);
    check("rstr_stall_first", stall_first - n0, 32'd1);
    check("rstr_stall_last",  stall_last - n0, 32'd31);
    check("rstr_done_lat",    done_cyc - n0, 32'd32);
    check("rstr_done_cnt",    done_cnt - d0, 32'd1);
    errs = 0;
    for (int i = 1; i < 32; i++) if (prf_mem[i] !== 32'(i + 1000)) errs++;
    check("rstr_data_errs", errs, 32'd0);
    check("rstr_x0_untouched", prf_mem[0], 32'hDEAD);
    check("rstr_sgpr_x7", sgpr_mem[7], 32'd1007);

    // 5: simultaneous requests pick restore; requests while busy ignored
    preload(3);
    d0 = done_cnt;
    p0 = prf_wr_cnt;
    ifc.ckpt_req_i = 1'b1;
    ifc.rstr_req_i = 1'b1;
    tick();
    ifc.ckpt_req_i = 1'b0;
    ifc.rstr_req_i = 1'b0;
    check("both_pick_rstr", {31'd0, ifc.core_stall_o}, 32'd1);
    repeat (4) tick();
    ifc.ckpt_req_i = 1'b1;
    ifc.rstr_req_i = 1'b1;
    tick();
    ifc.ckpt_req_i = 1'b0;
    ifc.rstr_req_i = 1'b0;
    run_until_idle(60);
    repeat (5) tick();
    check("busy_req_idle",    {31'd0, ifc.busy_o}, 32'd0);
    check("busy_req_done",    done_cnt - d0, 32'd1);
    check("busy_req_prf_wr",  prf_wr_cnt - p0, 32'd31);

    // 6: reset mid-checkpoint, then a full fresh walk
    preload(4);
    d0 = done_cnt;
    ifc.ckpt_req_i = 1'b1;
    tick();
    ifc.ckpt_req_i = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy",      {31'd0, ifc.busy_o}, 32'd0);
    check("abort_sgpr_we",   {31'd0, ifc.sgpr_we_a_o}, 32'd0);
    check("abort_prf_raddr", {27'd0, ifc.prf_raddr_o}, 32'd0);
    check("abort_done",      {31'd0, ifc.done_o}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_x9",  sgpr_mem[9], 32'd34);
    check("abort_x10", sgpr_mem[10], 32'd0);
    d0 = done_cnt;
    ifc.ckpt_req_i = 1'b1;
    n0 = cyc;
    tick();
    ifc.ckpt_req_i = 1'b0;
    run_until_idle(60);
    check("rewalk_done_cnt", done_cnt - d0, 32'd1);
    check("rewalk_done_lat", done_cyc - n0, 32'd32);
    errs = 0;
    for (int i = 1; i < 32; i++) if (sgpr_mem[i] !== 32'(i * 3 + 7)) errs++;
    check("rewalk_data_errs", errs, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
